// File: rtl/qspi_flash_responder.sv
// Quad-output (6Bh) SPI flash responder backed by a synchronous byte memory.
// SCK edge to pad/strobe latency is 3 clk; no backpressure: the host SCK paces everything and memory answers 1 clk after mem_rd.
module qspi_flash_responder #(
   parameter int         ADDR_W        = 24,
   parameter int         DUMMY_CYCLES  = 8,
   parameter logic [7:0] CMD_QUAD_READ = 8'h6B
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic [3:0]        spi_quad_in,
   output logic [3:0]        spi_quad_out,
   output logic [3:0]        spi_quad_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              bad_cmd
);

   localparam int CNT_MAX = (ADDR_W > DUMMY_CYCLES) ? ADDR_W : DUMMY_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      ADDR   = 3'd2,
      DUMMY  = 3'd3,
      DATA   = 3'd4,
      IGNORE = 3'd5
   } state_t;

   logic [1:0] cs_sync;
   logic [1:0] sck_sync;
   logic [1:0] io0_sync;
   logic       sck_prev;
   logic [1:0] sync_vld;

   logic cs_n_s;
   logic io0_s;
   logic sck_rise;
   logic sck_fall;
   logic unused_io;

   state_t              state_q,    state_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [ADDR_W-1:0]   shift_q,    shift_d;
   logic [ADDR_W-1:0]   shift_in;
   logic                nib_hi_q,   nib_hi_d;
   logic [3:0]          quad_out_q, quad_out_d;
   logic [3:0]          oe_q,       oe_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_rd_q,   mem_rd_d;
   logic                bad_cmd_q,  bad_cmd_d;
   logic                armed_q,    armed_d;
   logic                rd_pend_q;
   logic [7:0]          byte_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_sync  <= 2'b11;
         sck_sync <= 2'b00;
         io0_sync <= 2'b00;
         sck_prev <= 1'b0;
         sync_vld <= 2'b00;
      end else begin
         cs_sync  <= {cs_sync[0], spi_cs_n};
         sck_sync <= {sck_sync[0], spi_clk};
         io0_sync <= {io0_sync[0], spi_quad_in[0]};
         sck_prev <= sck_sync[1];
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   assign cs_n_s    = cs_sync[1];
   assign io0_s     = io0_sync[1];
   assign sck_rise  = sck_sync[1] & ~sck_prev;
   assign sck_fall  = ~sck_sync[1] & sck_prev;
   assign shift_in  = {shift_q[ADDR_W-2:0], io0_s};
   assign unused_io = ^spi_quad_in[3:1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      nib_hi_d   = nib_hi_q;
      quad_out_d = quad_out_q;
      oe_d       = oe_q;
      mem_addr_d = mem_addr_q;
      mem_rd_d   = 1'b0;
      bad_cmd_d  = 1'b0;
      // CS must be seen high with real pin data before a transaction may start,
      // so a reset released mid-transaction does not pick up a partial command.
      armed_d    = armed_q | (sync_vld[1] & cs_n_s);

      if (cs_n_s) begin
         state_d    = IDLE;
         cnt_d      = '0;
         nib_hi_d   = 1'b0;
         quad_out_d = '0;
         oe_d       = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (armed_q) begin
                  state_d = CMD;
                  cnt_d   = '0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  shift_d = shift_in;
                  if (cnt_q == CNT_W'(7)) begin
                     cnt_d = '0;
                     if (shift_in[7:0] == CMD_QUAD_READ) begin
                        state_d = ADDR;
                     end else begin
                        state_d   = IGNORE;
                        bad_cmd_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  shift_d = shift_in;
                  if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                     cnt_d      = '0;
                     mem_addr_d = shift_in;
                     mem_rd_d   = 1'b1;
                     state_d    = DUMMY;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            DUMMY: begin
               if (sck_rise) begin
                  if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                     cnt_d    = '0;
                     nib_hi_d = 1'b1;
                     state_d  = DATA;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            DATA: begin
               // Pads only change on a detected fall, so they are settled at the host's rise.
               if (sck_fall) begin
                  oe_d = 4'hF;
                  if (nib_hi_q) begin
                     quad_out_d = byte_q[7:4];
                     nib_hi_d   = 1'b0;
                  end else begin
                     quad_out_d = byte_q[3:0];
                     nib_hi_d   = 1'b1;
                     mem_addr_d = mem_addr_q + ADDR_W'(1);
                     mem_rd_d   = 1'b1;
                  end
               end
            end
            IGNORE: begin
               oe_d = '0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         nib_hi_q   <= 1'b0;
         quad_out_q <= '0;
         oe_q       <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         bad_cmd_q  <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         nib_hi_q   <= nib_hi_d;
         quad_out_q <= quad_out_d;
         oe_q       <= oe_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
         bad_cmd_q  <= bad_cmd_d;
         armed_q    <= armed_d;
      end
   end

   // Read data is valid the clk after the strobe; capture it then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend_q <= 1'b0;
         byte_q    <= '0;
      end else begin
         rd_pend_q <= mem_rd_q;
         if (rd_pend_q) begin
            byte_q <= mem_rdata;
         end
      end
   end

   assign spi_quad_out = quad_out_q;
   assign spi_quad_oe  = oe_q;
   assign mem_addr     = mem_addr_q;
   assign mem_rd       = mem_rd_q;
   assign bad_cmd      = bad_cmd_q;
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: mode-0 quad-read host model, synchronous memory model,
// scoreboards for data nibbles and memory read addresses.
module tb_qspi_flash_responder;

   logic        clk;
   logic        rst;
   logic        spi_cs_n;
   logic        spi_clk;
   logic [3:0]  spi_quad_in;
   logic [3:0]  spi_quad_out;
   logic [3:0]  spi_quad_oe;
   logic [23:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        bad_cmd;

   int checks = 0;
   int errors = 0;
   int bad_cycles = 0;

   logic [7:0]  mem_over [int];
   logic [3:0]  exp_nib [$];
   logic [23:0] exp_rd [$];
   logic [23:0] rd_a;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      int          ndata;
      int          half;
      int          exp_bad;
      logic [7:0]  exp_first;
   } vec_t;

   vec_t vecs [8];

   qspi_flash_responder #(
      .ADDR_W(24),
      .DUMMY_CYCLES(8),
      .CMD_QUAD_READ(8'h6B)
   ) dut (
      .clk(clk),
      .rst(rst),
      .spi_cs_n(spi_cs_n),
      .spi_clk(spi_clk),
      .spi_quad_in(spi_quad_in),
      .spi_quad_out(spi_quad_out),
      .spi_quad_oe(spi_quad_oe),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_rdata(mem_rdata),
      .busy(busy),
      .bad_cmd(bad_cmd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      if (mem_over.exists(int'({8'h00, a}))) return mem_over[int'({8'h00, a})];
      return a[7:0];
   endfunction

   // Synchronous memory: data valid the clk after the strobe.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem_byte(mem_addr);
   end

   always @(negedge clk) begin
      if (!rst && mem_rd) begin
         checks++;
         if (exp_rd.size() == 0) begin
            errors++;
            $display("FAIL mem_rd_unexpected: got read at %h, required no read", mem_addr);
         end else begin
            rd_a = exp_rd.pop_front();
            if (mem_addr !== rd_a) begin
               errors++;
               $display("FAIL mem_addr: got %h, required %h", mem_addr, rd_a);
            end
         end
      end
      if (bad_cmd) bad_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // One mode-0 SCK period: IO0 set in the low phase, pads sampled at the rise.
   task automatic sck_clock(input logic mosi, input int half, output logic [3:0] d, output logic [3:0] oe);
      spi_quad_in = {3'b000, mosi};
      repeat (half) tick();
      spi_clk = 1'b1;
      d  = spi_quad_out;
      oe = spi_quad_oe;
      repeat (half) tick();
      spi_clk = 1'b0;
   endtask

   task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int n,
                          input int half, input int exp_bad, output logic [7:0] first);
      logic [3:0]  d, oe, e;
      logic [7:0]  b;
      logic        good;
      int          oe_nz;
      good = (op == 8'h6B);
      oe_nz = 0;
      first = 8'h00;
      bad_cycles = 0;
      if (good) begin
         for (int k = 0; k < n; k++) begin
            b = mem_byte(addr + 24'(k / 2));
            exp_nib.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
         end
         // initial fetch plus one prefetch per low nibble driven (falls drive nibbles 0..n)
         for (int j = 0; j <= (n + 1) / 2; j++) exp_rd.push_back(addr + 24'(j));
      end
      spi_cs_n = 1'b0;
      repeat (half) tick();
      for (int i = 7; i >= 0; i--) begin
         sck_clock(op[i], half, d, oe);
         if (oe != 4'h0) oe_nz++;
      end
      for (int i = 23; i >= 0; i--) begin
         sck_clock(addr[i], half, d, oe);
         if (oe != 4'h0) oe_nz++;
      end
      for (int i = 0; i < 8; i++) begin
         sck_clock(1'b0, half, d, oe);
         if (oe != 4'h0) oe_nz++;
      end
      for (int i = 0; i < n; i++) begin
         sck_clock(1'b0, half, d, oe);
         if (good) begin
            e = (exp_nib.size() > 0) ? exp_nib.pop_front() : 4'hx;
            chk("data_nibble_oe", {24'h0, oe, d}, {24'h0, 4'hF, e});
            if (i == 0) first[7:4] = d;
            if (i == 1) first[3:0] = d;
         end else if (oe != 4'h0) begin
            oe_nz++;
         end
      end
      repeat (half) tick();
      spi_cs_n = 1'b1;
      repeat (4) tick();
      chk("busy_after_cs", {31'h0, busy}, 32'h0);
      chk("oe_after_cs", {28'h0, spi_quad_oe}, 32'h0);
      chk("oe_outside_data", oe_nz, 0);
      chk("reads_outstanding", exp_rd.size(), 0);
      chk("bad_cmd_cycles", bad_cycles, exp_bad);
      exp_nib.delete();
      exp_rd.delete();
      repeat (3) tick();
   endtask

   initial begin
      logic [7:0] first;
      logic [3:0] d, oe;
      logic [7:0] cmd;
      logic [23:0] a;
      int busy_seen;

      rst = 1'b1;
      spi_cs_n = 1'b1;
      spi_clk = 1'b0;
      spi_quad_in = 4'h0;
      #12;
      chk("rst_quad_out", {28'h0, spi_quad_out}, 32'h0);
      chk("rst_oe", {28'h0, spi_quad_oe}, 32'h0);
      chk("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
      chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_bad_cmd", {31'h0, bad_cmd}, 32'h0);
      rst = 1'b0;
      repeat (4) tick();

      mem_over[32'h00FFFFFF] = 8'hA5;
      mem_over[32'h00000000] = 8'h3C;
      for (int i = 0; i < 100; i++) mem_over[32'h400 + i] = 8'($urandom_range(0, 255));

      vecs[0] = '{8'h6B, 24'h000010,   8, 4, 0, 8'h10};
      vecs[1] = '{8'h03, 24'h000010,   8, 4, 1, 8'h00};
      vecs[2] = '{8'h6B, 24'h000020,   8, 4, 0, 8'h20};
      vecs[3] = '{8'h6B, 24'hFFFFFF,   4, 4, 0, 8'hA5};
      vecs[4] = '{8'h6B, 24'h000050,   3, 4, 0, 8'h50};
      vecs[5] = '{8'h6B, 24'h000100,   8, 6, 0, 8'h00};
      vecs[6] = '{8'h6A, 24'h000040,   2, 4, 1, 8'h00};
      vecs[7] = '{8'h6B, 24'h000400, 200, 4, 0, mem_over[32'h400]};

      for (int v = 0; v < 8; v++) begin
         run_txn(vecs[v].op, vecs[v].addr, vecs[v].ndata, vecs[v].half, vecs[v].exp_bad, first);
         if (vecs[v].exp_bad == 0) chk("first_byte", {24'h0, first}, {24'h0, vecs[v].exp_first});
      end

      // Async reset in the middle of a data stream with CS held low.
      cmd = 8'h6B;
      a = 24'h000030;
      exp_rd.push_back(24'h000030);
      exp_rd.push_back(24'h000031);
      spi_cs_n = 1'b0;
      repeat (4) tick();
      for (int i = 7; i >= 0; i--) sck_clock(cmd[i], 4, d, oe);
      for (int i = 23; i >= 0; i--) sck_clock(a[i], 4, d, oe);
      for (int i = 0; i < 8; i++) sck_clock(1'b0, 4, d, oe);
      sck_clock(1'b0, 4, d, oe);
      chk("rstseq_nib0", {24'h0, oe, d}, {24'h0, 4'hF, 4'h3});
      sck_clock(1'b0, 4, d, oe);
      chk("rstseq_nib1", {24'h0, oe, d}, {24'h0, 4'hF, 4'h0});
      repeat (4) tick();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_oe", {28'h0, spi_quad_oe}, 32'h0);
      chk("async_rst_out", {28'h0, spi_quad_out}, 32'h0);
      chk("async_rst_busy", {31'h0, busy}, 32'h0);
      chk("rstseq_reads", exp_rd.size(), 0);
      exp_rd.delete();
      repeat (2) tick();
      rst = 1'b0;
      busy_seen = 0;
      repeat (3) tick();
      for (int r = 0; r < 2; r++) begin
         for (int i = 7; i >= 0; i--) begin
            sck_clock(cmd[i], 4, d, oe);
            if (busy) busy_seen++;
         end
      end
      chk("idle_until_cs_cycles", busy_seen, 0);
      spi_cs_n = 1'b1;
      repeat (6) tick();
      run_txn(8'h6B, 24'h000010, 8, 4, 0, first);
      chk("post_reset_first_byte", {24'h0, first}, 32'h10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable responder for the slave end of the Winbond 6Bh Fast Read Quad Output protocol.
- Emulates the flash toward the on-chip quad-SPI reader so the video player runs from BRAM/SDRAM on FPGA builds and in system sims.
- All SPI inputs are oversampled on the single system clock.
- Data bytes are fetched from a simple synchronous memory read port.

Parameters:
ADDR_W, 24, address width; the address wraps modulo 2^ADDR_W
DUMMY_CYCLES, 8, SCK rising edges between the last address bit and the first data nibble
CMD_QUAD_READ, 8'h6B, the only accepted command opcode

Ports:
clk  input  1  system clock; must be >= 8x SCK, with each SCK half-period >= 4 clk
rst  input  1  reset, asynchronous, active-high
spi_cs_n  input  1  chip select from host, active low
spi_clk  input  1  SCK from host, mode 0
spi_quad_in  input  4  IO0-IO3 from host; only IO0 is used (command/address phase)
spi_quad_out  output  4  data nibble to host, IO3 = MSB
spi_quad_oe  output  4  pad output enables; 4'hF only while driving data
mem_addr  output  ADDR_W  byte address to backing memory
mem_rd  output  1  one-clk read strobe
mem_rdata  input  8  read data, valid exactly 1 clk after mem_rd
busy  output  1  high when state != IDLE
bad_cmd  output  1  one-clk pulse when the received opcode != CMD_QUAD_READ

Behaviour:
- Reset (async, immediate): spi_quad_out=0, spi_quad_oe=0, mem_addr=0, mem_rd=0, busy=0, bad_cmd=0, state=IDLE, synchronizers loaded with idle levels (cs_n=1, sck=0).
- Input sampling:
  - spi_cs_n, spi_clk and IO0 each pass through a 2-flop synchronizer.
  - SCK rise/fall are detected by comparing synchronized SCK to its previous value.
  - Edge-to-action latency is <= 4 clk.
- CS high, any state: synchronized cs_n=1 forces IDLE on the next clk. Same clk: oe=0, quad_out=0, counters cleared. Partial bytes and commands are discarded.
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA; a bad opcode goes to IGNORE.
- IDLE:
  - Wait for synchronized cs_n=0, then go to CMD with bit counter 0.
  - SCK edges seen while cs_n=1 are ignored.
- CMD:
  - Shift IO0 MSB-first on each SCK rise; 8 rises total.
  - On the 8th rise: opcode == CMD_QUAD_READ -> ADDR; otherwise pulse bad_cmd for 1 clk and go to IGNORE.
- IGNORE: outputs stay tri-stated (oe=0) until CS goes high.
- ADDR:
  - Shift IO0 MSB-first on each SCK rise; ADDR_W rises total.
  - On the last rise: mem_addr <= shifted address, mem_rd pulses next clk, go to DUMMY.
- DUMMY:
  - Count DUMMY_CYCLES SCK rises with oe=0.
  - mem_rdata is captured into the byte register 1 clk after mem_rd.
  - After the final dummy rise, go to DATA with nibble select = high.
- DATA:
  - On each SCK fall, drive spi_quad_out from the byte register (high nibble first, then low) with oe=4'hF.
  - Output changes only on detected SCK falls, so it is stable across the host's sampling rise.
  - On the low-nibble fall: mem_addr <= mem_addr+1 (wrapping all-ones -> 0), mem_rd pulses the next clk, and the byte register reloads 1 clk later. The next byte is ready well before the next fall.
  - Streaming is continuous and unlimited until CS goes high.
- Simultaneous events: a CS rise takes priority over an SCK edge in the same clk. mem_rdata capture still completes but has no effect after IDLE.
- mem_rd is never asserted outside ADDR->DUMMY and DATA; there is at most one outstanding read.

Test Plan:
- Reset: assert rst mid-stream with CS low -> oe=0, quad_out=0, busy=0 on the same cycle (async). Deassert rst, CS still low -> state IDLE until CS cycles high.
- Nominal read: CS low, opcode 6Bh, address 0x000010, 8 dummy clocks, 8 data clocks, memory byte = low address byte -> nibbles 1,0,1,1,1,2,1,3; mem_addr 0x10..0x13; oe=F only during data.
- Bad opcode 03h -> bad_cmd one-clk pulse after 8th SCK rise; oe stays 0 through 40 further SCK clocks; busy drops after CS high; a following 6Bh transaction returns correct data.
- Wrap: address 0xFFFFFF, 4 data clocks, mem[FFFFFF]=A5, mem[0]=3C -> nibbles A,5,3,C; mem_addr FFFFFF then 000000.
- Abort: CS high after 3 data nibbles -> oe=0 within 4 clk, busy=0. Next transaction at 0x000100 streams from 0x100.
- Against the on-chip reader: SCK = clk/8 for 100 bytes of random memory; every captured byte matches; no mem_rd outside the allowed windows.
